// File: rtl/writeback_stage.sv
// -----------------------------------------------------------------------------
// writeback_stage
//   Writeback (W) stage of the pipelined Y86-style CPU. Holds the W pipeline
//   register fed by the memory stage, drives the write side of the register
//   file (which decode also uses as its W-stage forwarding source), owns the
//   sticky RUN/HALTED state machine and counts retired instructions.
//
// Ports:
//   CLK, RST          clock (rising edge), asynchronous active-high reset
//   W_stall, W_bubble hold / squash the W register (stall has priority)
//   m_stat            memory-stage status (1=AOK, 2=HLT, 3=ADR, 4=INS)
//   m_valE, m_valM    E and M result values from the memory stage
//   m_dstE, m_dstM    E and M destination indices from the memory stage
//   valE, valM        register file write data, E and M ports
//   destE, destM      register file write indices (RNONE = no write)
//   w_valid           W register holds a real instruction
//   Stat              processor status (AOK while running)
//   halted            processor stopped, left only by reset
//   retired           retired-instruction count, wraps modulo 2^CNT_WID
// -----------------------------------------------------------------------------
module writeback_stage #(
   parameter int                  DATA_WID = 64,
   parameter int                  ADDR_WID = 4,
   parameter logic [ADDR_WID-1:0] RNONE    = 4'hF,
   parameter int                  CNT_WID  = 32
) (
   input  logic                CLK,
   input  logic                RST,
   input  logic                W_stall,
   input  logic                W_bubble,
   input  logic [2:0]          m_stat,
   input  logic [DATA_WID-1:0] m_valE,
   input  logic [DATA_WID-1:0] m_valM,
   input  logic [ADDR_WID-1:0] m_dstE,
   input  logic [ADDR_WID-1:0] m_dstM,
   output logic [DATA_WID-1:0] valE,
   output logic [DATA_WID-1:0] valM,
   output logic [ADDR_WID-1:0] destE,
   output logic [ADDR_WID-1:0] destM,
   output logic                w_valid,
   output logic [2:0]          Stat,
   output logic                halted,
   output logic [CNT_WID-1:0]  retired
);

   localparam logic [2:0] SAOK = 3'd1;

   typedef enum logic {
      RUN    = 1'b0,
      HALTED = 1'b1
   } state_t;

   // W pipeline register
   logic                W_valid;
   logic [2:0]          W_stat;
   logic [DATA_WID-1:0] W_valE;
   logic [DATA_WID-1:0] W_valM;
   logic [ADDR_WID-1:0] W_dstE;
   logic [ADDR_WID-1:0] W_dstM;
   logic                W_done;

   state_t              state;
   logic [2:0]          statReg;
   logic                haltedReg;
   logic [CNT_WID-1:0]  retiredReg;

   logic                wrEn;
   logic                collide;
   logic                countNow;

   // A faulting instruction (W_stat != AOK) and anything after a halt must
   // never reach the register file.
   assign wrEn     = W_valid && (W_stat == SAOK) && (state == RUN);
   // popq %rsp: both ports target the same register, the loaded value wins.
   assign collide  = (W_dstE == W_dstM) && (W_dstE != RNONE);
   // W_done keeps a stalled instruction from being counted on every cycle
   // its (idempotent) register write is repeated.
   assign countNow = wrEn && !W_done;

   always_comb begin
      destE = RNONE;
      destM = RNONE;
      valE  = '0;
      valM  = '0;
      if (wrEn) begin
         destE = collide ? RNONE : W_dstE;
         destM = W_dstM;
         valE  = W_valE;
         valM  = W_valM;
      end
   end

   assign w_valid = W_valid;
   assign Stat    = statReg;
   assign halted  = haltedReg;
   assign retired = retiredReg;

   always_ff @(posedge CLK or posedge RST) begin
      if (RST) begin
         W_valid    <= 1'b0;
         W_stat     <= SAOK;
         W_valE     <= '0;
         W_valM     <= '0;
         W_dstE     <= RNONE;
         W_dstM     <= RNONE;
         W_done     <= 1'b0;
         state      <= RUN;
         statReg    <= SAOK;
         haltedReg  <= 1'b0;
         retiredReg <= '0;
      end else if (state == RUN) begin
         if (countNow) begin
            retiredReg <= retiredReg + CNT_WID'(1);
         end

         if (W_valid && (W_stat != SAOK)) begin
            state     <= HALTED;
            haltedReg <= 1'b1;
            statReg   <= W_stat;
         end

         if (W_stall) begin
            W_done <= W_done | countNow;
         end else if (W_bubble) begin
            W_valid <= 1'b0;
            W_stat  <= SAOK;
            W_valE  <= '0;
            W_valM  <= '0;
            W_dstE  <= RNONE;
            W_dstM  <= RNONE;
            W_done  <= 1'b0;
         end else begin
            W_valid <= 1'b1;
            W_stat  <= m_stat;
            W_valE  <= m_valE;
            W_valM  <= m_valM;
            W_dstE  <= m_dstE;
            W_dstM  <= m_dstM;
            W_done  <= 1'b0;
         end
      end
      // HALTED: everything frozen until reset.
   end

endmodule

// File: tb/tb_writeback_stage.sv
// -----------------------------------------------------------------------------
// tb_writeback_stage
//   Self-checking bench for writeback_stage: directed scenarios with literal
//   expectations, then randomized episodes compared every cycle against a
//   behavioural model (model W slot, model register file, model counter).
//   The counter width is shrunk to 4 bits so wrap-around is exercised.
// -----------------------------------------------------------------------------
module tb_writeback_stage;

   localparam int         CW = 4;
   localparam logic [3:0] RN = 4'hF;

   logic          CLK = 1'b0;
   logic          RST = 1'b0;
   logic          W_stall = 1'b0;
   logic          W_bubble = 1'b0;
   logic [2:0]    m_stat = 3'd1;
   logic [63:0]   m_valE = '0;
   logic [63:0]   m_valM = '0;
   logic [3:0]    m_dstE = 4'hF;
   logic [3:0]    m_dstM = 4'hF;
   logic [63:0]   valE, valM;
   logic [3:0]    destE, destM;
   logic          w_valid;
   logic [2:0]    Stat;
   logic          halted;
   logic [CW-1:0] retired;

   writeback_stage #(
      .DATA_WID(64), .ADDR_WID(4), .RNONE(4'hF), .CNT_WID(CW)
   ) dut (
      .CLK(CLK), .RST(RST), .W_stall(W_stall), .W_bubble(W_bubble),
      .m_stat(m_stat), .m_valE(m_valE), .m_valM(m_valM),
      .m_dstE(m_dstE), .m_dstM(m_dstM),
      .valE(valE), .valM(valM), .destE(destE), .destM(destM),
      .w_valid(w_valid), .Stat(Stat), .halted(halted), .retired(retired)
   );

   always #5 CLK = ~CLK;

   int nChecks = 0;
   int nErr = 0;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      nChecks++;
      if (act !== exp) begin
         nErr++;
         $display("FAIL %s at %0t: got %0h expected %0h", name, $time, act, exp);
      end
   endtask

   // Register file written from the DUT's write ports (M written last so it
   // wins on any shared index).
   logic [63:0] rf [16];
   always @(posedge CLK) begin
      if (destE != RN) rf[destE] <= valE;
      if (destM != RN) rf[destM] <= valM;
   end

   // ---------------- behavioural model ----------------
   typedef struct {
      logic        valid;
      logic [2:0]  stat;
      logic [63:0] vE;
      logic [63:0] vM;
      logic [3:0]  dE;
      logic [3:0]  dM;
      logic        counted;
   } inst_t;

   localparam inst_t EMPTY = '{valid: 1'b0, stat: 3'd1, vE: 64'd0, vM: 64'd0,
                               dE: 4'hF, dM: 4'hF, counted: 1'b0};

   inst_t         mW;
   logic          mHalted;
   logic [2:0]    mStat;
   logic [CW-1:0] mRetired;
   logic [63:0]   mRF [16];

   function automatic logic mWrites();
      return mW.valid && (mW.stat == 3'd1) && !mHalted;
   endfunction

   always @(posedge CLK or posedge RST) begin
      if (RST) begin
         mW       = EMPTY;
         mHalted  = 1'b0;
         mStat    = 3'd1;
         mRetired = '0;
      end else if (!mHalted) begin
         if (mWrites()) begin
            mRF[mW.dE] = (mW.dE != RN) ? mW.vE : mRF[mW.dE];
            if (mW.dM != RN) mRF[mW.dM] = mW.vM;
            if (!mW.counted) begin
               mRetired   = mRetired + 1'b1;
               mW.counted = 1'b1;
            end
         end
         if (mW.valid && mW.stat != 3'd1) begin
            mHalted = 1'b1;
            mStat   = mW.stat;
         end
         if (!W_stall) begin
            if (W_bubble) mW = EMPTY;
            else mW = '{valid: 1'b1, stat: m_stat, vE: m_valE, vM: m_valM,
                        dE: m_dstE, dM: m_dstM, counted: 1'b0};
         end
      end
   end

   // ---------------- per-cycle compare ----------------
   always @(negedge CLK) begin
      logic en;
      int bad;
      en = mWrites();
      chk("destM", destM, en ? mW.dM : RN);
      chk("destE", destE, (en && mW.dE != mW.dM) ? mW.dE : RN);
      chk("valE", valE, en ? mW.vE : 64'd0);
      chk("valM", valM, en ? mW.vM : 64'd0);
      chk("w_valid", w_valid, mW.valid);
      chk("Stat", Stat, mHalted ? mStat : 3'd1);
      chk("halted", halted, mHalted);
      chk("retired", retired, mRetired);
      bad = 0;
      for (int i = 0; i < 16; i++) if (rf[i] !== mRF[i]) bad = i;
      chk("regfile", rf[bad], mRF[bad]);
   end

   // ---------------- stimulus ----------------
   task automatic drv(input logic s, input logic b, input logic [2:0] st,
                      input logic [63:0] ve, input logic [63:0] vm,
                      input logic [3:0] de, input logic [3:0] dm);
      W_stall = s; W_bubble = b; m_stat = st;
      m_valE = ve; m_valM = vm; m_dstE = de; m_dstM = dm;
   endtask

   task automatic edgeStep();
      @(negedge CLK);
   endtask

   task automatic drvRandom(input int haltOdds);
      logic [3:0] de, dm;
      logic [2:0] st;
      de = 4'($urandom_range(0, 15));
      dm = ($urandom_range(0, 7) == 0) ? de : 4'($urandom_range(0, 15));
      st = ($urandom_range(0, haltOdds) == 0) ? 3'($urandom_range(2, 4)) : 3'd1;
      drv($urandom_range(0, 4) == 0, $urandom_range(0, 5) == 0, st,
          {$urandom, $urandom}, {$urandom, $urandom}, de, dm);
   endtask

   initial begin
      for (int i = 0; i < 16; i++) begin
         rf[i]  = '0;
         mRF[i] = '0;
      end
      #1 RST = 1'b1;
      repeat (2) edgeStep();
      chk("rst destE", destE, RN);
      chk("rst valE", valE, 0);
      chk("rst Stat", Stat, 1);
      chk("rst halted", halted, 0);
      chk("rst retired", retired, 0);
      chk("rst w_valid", w_valid, 0);
      #1 RST = 1'b0;

      // Simple write to register 2
      drv(0, 0, 1, 64'h55, 64'h0, 4'd2, RN);
      edgeStep();
      chk("ld destE", destE, 2);
      chk("ld valE", valE, 64'h55);
      chk("ld destM", destM, RN);
      #1 drv(1, 0, 1, 64'h55, 64'h0, 4'd2, RN);
      edgeStep();
      chk("rf2", rf[2], 64'h55);
      chk("retired1", retired, 1);
      for (int k = 0; k < 2; k++) begin
         edgeStep();
         chk("stall destE", destE, 2);
         chk("stall retired", retired, 1);
      end
      #1 drv(0, 0, 1, 64'h77, 64'h0, 4'd3, RN);
      edgeStep();
      chk("new destE", destE, 3);
      chk("new retired", retired, 1);

      // Collision: M value wins
      #1 drv(0, 0, 1, 64'h10, 64'h20, 4'd4, 4'd4);
      edgeStep();
      chk("retired2", retired, 2);
      chk("coll destE", destE, RN);
      chk("coll destM", destM, 4);
      #1 drv(0, 1, 1, 64'h0, 64'h0, RN, RN);
      edgeStep();
      chk("rf4", rf[4], 64'h20);
      chk("retired3", retired, 3);
      chk("bub destE", destE, RN);
      chk("bub destM", destM, RN);
      chk("bub w_valid", w_valid, 0);
      #1 drv(0, 0, 1, 64'h66, 64'h0, 4'd6, RN);
      edgeStep();
      chk("i6 destE", destE, 6);
      #1 drv(1, 1, 1, 64'h99, 64'h0, 4'd7, RN);
      edgeStep();
      chk("stall+bub destE", destE, 6);
      chk("stall+bub valE", valE, 64'h66);
      chk("stall+bub w_valid", w_valid, 1);
      chk("retired4", retired, 4);

      // Address fault on a write to register 1
      #1 drv(0, 0, 3, 64'h99, 64'h0, 4'd1, RN);
      edgeStep();
      chk("adr destE", destE, RN);
      chk("adr valE", valE, 0);
      chk("adr halted", halted, 0);
      #1 drv(0, 0, 1, 64'h123, 64'h0, 4'd1, RN);
      edgeStep();
      chk("adr halted1", halted, 1);
      chk("adr Stat", Stat, 3);
      chk("adr rf1", rf[1], 0);
      for (int k = 0; k < 3; k++) begin
         #1 drvRandom(1000);
         edgeStep();
         chk("halt Stat", Stat, 3);
         chk("halt destE", destE, RN);
      end
      #1 RST = 1'b1;
      #2 RST = 1'b0;
      drv(0, 1, 1, 0, 0, RN, RN);
      edgeStep();
      chk("post rst halted", halted, 0);
      chk("post rst Stat", Stat, 1);
      chk("post rst retired", retired, 0);

      // Asynchronous reset between edges
      #1 drv(0, 0, 1, 64'hAB, 64'h0, 4'd5, RN);
      @(posedge CLK);
      #2 chk("async pre destE", destE, 5);
      RST = 1'b1;
      #1 chk("async destE", destE, RN);
      chk("async valE", valE, 0);
      edgeStep();
      #1 RST = 1'b0;

      // Randomized episodes, each ended by a reset
      for (int ep = 0; ep < 6; ep++) begin
         for (int c = 0; c < 150; c++) begin
            drvRandom(40);
            edgeStep();
            #1;
         end
         RST = 1'b1;
         #3 RST = 1'b0;
      end

      edgeStep();
      $display("Result: errors=%0d of %0d checks", nErr, nChecks);
      $finish;
   end

endmodule

// File: doc/writeback_stage.md
Name: writeback_stage

Overview:
- Writeback (W) stage of the pipelined Y86-style CPU.
- Holds the W pipeline register fed by the memory stage and drives the write side of the register file (valE, valM, destE, destM).
- Exports W-stage forwarding values to decode and the processor status.
- Owns the sticky halt state machine and a retired-instruction counter.

Parameters:
- DATA_WID, 64, register/data width
- ADDR_WID, 4, register index width
- RNONE, 4'hF, "no register" index; a write to RNONE is a no-op at the register file
- CNT_WID, 32, retired-instruction counter width

Ports:
- CLK  input  1  clock, rising edge
- RST  input  1  reset, asynchronous, active-high
- W_stall  input  1  hold W register contents
- W_bubble  input  1  load a bubble into the W register
- m_stat  input  3  memory-stage status: 1=AOK, 2=HLT, 3=ADR, 4=INS
- m_valE  input  DATA_WID  ALU result from memory stage
- m_valM  input  DATA_WID  memory read data from memory stage
- m_dstE  input  ADDR_WID  E destination from memory stage
- m_dstM  input  ADDR_WID  M destination from memory stage
- valE  output  DATA_WID  register file write data, E port
- valM  output  DATA_WID  register file write data, M port
- destE  output  ADDR_WID  register file write index, E port
- destM  output  ADDR_WID  register file write index, M port
- w_valid  output  1  W register holds a real instruction (not a bubble)
- Stat  output  3  processor status
- halted  output  1  processor stopped
- retired  output  CNT_WID  count of retired instructions

Behaviour:
- W register fields:
  - W_valid, W_stat, W_valE, W_valM, W_dstE, W_dstM
  - W_done: the instruction has already been counted
- Reset (async, RST=1):
  - W_valid=0, W_stat=AOK, W_valE=W_valM=0, W_dstE=W_dstM=RNONE, W_done=0
  - state=RUN, retired=0
  - Outputs: valE=valM=0, destE=destM=RNONE, Stat=AOK, halted=0, w_valid=0
  - Reset mid-operation discards the W contents immediately; no write port is asserted while RST=1.
- W register update at posedge, state RUN (priority order):
  - W_stall=1: hold all fields. Stall wins over bubble.
  - W_bubble=1: load W_valid=0, W_stat=AOK, W_dstE=W_dstM=RNONE, W_valE=W_valM=0, W_done=0.
  - Otherwise: load the m_* inputs, W_valid=1, W_done=0.
- State HALTED: the W register is frozen; inputs and stall/bubble are ignored.
- Write ports are combinational from the W register (latency: captured at edge N, written into the register file at edge N+1):
  - Writes are enabled only when W_valid=1, W_stat=AOK and state=RUN.
  - If enabled: destE=W_dstE, destM=W_dstM, valE=W_valE, valM=W_valM.
  - If disabled: destE=destM=RNONE, valE=valM=0.
  - Collision: if enabled, W_dstE==W_dstM and W_dstE!=RNONE, force destE=RNONE, so the M value wins (popq %rsp semantics).
- w_valid reflects W_valid.
- Forwarding to decode uses destE/destM/valE/valM exactly as driven; no extra ports.
- State machine RUN -> HALTED:
  - Transition at posedge when W_valid=1 and W_stat!=AOK.
  - The faulting instruction never writes registers and is not counted.
- HALTED is left only by reset.
- Stat:
  - In RUN: AOK.
  - In HALTED: the W_stat captured at the transition, held until reset.
  - halted=1 exactly when state=HALTED.
- Retired counter:
  - At posedge, if write enabled and W_done=0: retired+=1 and W_done=1.
  - A stalled instruction is counted once even though its register write repeats each cycle (idempotent).
  - The counter wraps modulo 2^CNT_WID.
- Bubbles never count and never write.

Test Plan:
- Reset then m_stat=1, m_dstE=2, m_valE=0x55, m_dstM=RNONE, one edge -> destE=2, valE=0x55, destM=RNONE in the next cycle; register 2 reads 0x55 after the following edge; retired=1.
- Same instruction held with W_stall=1 for 3 cycles -> destE stays 2, retired stays 1; release stall with a new instruction -> retired=2.
- Collision: m_dstE=m_dstM=4, m_valE=0x10, m_valM=0x20 -> destE=RNONE, destM=4; register 4 = 0x20.
- W_bubble=1 with W_stall=0 -> destE=destM=RNONE, w_valid=0, retired unchanged; W_bubble=1 together with W_stall=1 -> W contents unchanged.
- m_stat=3 (ADR) with m_dstE=1 loaded -> no write to register 1 on that cycle; at the next edge halted=1, Stat=3; further inputs ignored, Stat stays 3; RST pulse -> halted=0, Stat=1, retired=0.
- Assert RST asynchronously between edges while destE=5 -> destE=RNONE and valE=0 immediately, before the next CLK edge.
